// File: rtl/nios_accelerometer_hex_ctrl_if.sv
// Avalon-MM slave bus for the seven-segment display controller.
// The master modport drives the register access; the slave answers with readdata.
interface nios_accelerometer_hex_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_accelerometer_hex_ctrl.sv
// Six-digit seven-segment display controller for the accelerometer Nios system.
// Software writes one signed 16-bit value; the block shows it as signed decimal
// (sequential double-dabble, 16 shift cycles) or as raw hex, with optional
// leading-zero blanking. Segment patterns are active-low, bit[6:0] = g..a.
module nios_accelerometer_hex_ctrl (
  input  logic                                clk,
  input  logic                                reset_n,
  nios_accelerometer_hex_ctrl_if.slave        bus,
  output logic [6:0]                          hex0,
  output logic [6:0]                          hex1,
  output logic [6:0]                          hex2,
  output logic [6:0]                          hex3,
  output logic [6:0]                          hex4,
  output logic [6:0]                          hex5
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    LOAD  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Hex digit to active-low segment pattern.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [19:0] bcd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  state_t      state_r;
  logic [15:0] value_r;
  logic [2:0]  ctrl_r;
  logic        busy_r;
  logic        dropped_r;
  logic        hexmode_r;
  logic        blank_r;
  logic        neg_r;
  logic [19:0] bcd_r;
  logic [15:0] mag_r;
  logic [4:0]  cnt_r;
  logic [6:0]  digit0_r, digit1_r, digit2_r, digit3_r, digit4_r, digit5_r;

  logic        wr_s, wr_value_s, wr_ctrl_s, wr_status_s, accept_s;
  logic [35:0] shifted_s;
  logic [19:0] adj_s;
  logic        lead4_s, lead3_s, lead2_s, lead1_s;
  logic [6:0]  next0_s, next1_s, next2_s, next3_s, next4_s, next5_s;
  logic        unused_bits;

  assign wr_s        = bus.chipselect & ~bus.write_n;
  assign wr_value_s  = wr_s & (bus.address == 2'd0);
  assign wr_ctrl_s   = wr_s & (bus.address == 2'd1);
  assign wr_status_s = wr_s & (bus.address == 2'd2);
  assign accept_s    = wr_value_s & ~busy_r;
  assign unused_bits = ^bus.writedata[31:16];

  // One double-dabble iteration: correct nibbles, then shift {bcd, mag} left.
  always_comb begin
    adj_s     = bcd_adjust(bcd_r);
    shifted_s = {adj_s[18:0], mag_r, 1'b0};
  end

  // Digit patterns written at LOAD, with leading-zero blanking from hex4 down.
  always_comb begin
    lead4_s = blank_r & (bcd_r[19:16] == 4'd0);
    lead3_s = lead4_s & (bcd_r[15:12] == 4'd0);
    lead2_s = lead3_s & (bcd_r[11:8] == 4'd0);
    lead1_s = lead2_s & (bcd_r[7:4] == 4'd0);
    next0_s = SEG_ZERO;
    next1_s = SEG_BLANK;
    next2_s = SEG_BLANK;
    next3_s = SEG_BLANK;
    next4_s = SEG_BLANK;
    next5_s = SEG_BLANK;
    if (hexmode_r) begin
      next3_s = glyph(mag_r[15:12]);
      next2_s = glyph(mag_r[11:8]);
      next1_s = glyph(mag_r[7:4]);
      next0_s = glyph(mag_r[3:0]);
    end else begin
      next5_s = neg_r   ? SEG_MINUS : SEG_BLANK;
      next4_s = lead4_s ? SEG_BLANK : glyph(bcd_r[19:16]);
      next3_s = lead3_s ? SEG_BLANK : glyph(bcd_r[15:12]);
      next2_s = lead2_s ? SEG_BLANK : glyph(bcd_r[11:8]);
      next1_s = lead1_s ? SEG_BLANK : glyph(bcd_r[7:4]);
      next0_s = glyph(bcd_r[3:0]);
    end
  end

  // Software-visible registers: VALUE, CTRL and the sticky dropped flag (set wins).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_r   <= 16'd0;
      ctrl_r    <= 3'b101;
      dropped_r <= 1'b0;
    end else begin
      if (accept_s) begin
        value_r <= bus.writedata[15:0];
      end
      if (wr_ctrl_s) begin
        ctrl_r <= bus.writedata[2:0];
      end
      if (wr_value_s && busy_r) begin
        dropped_r <= 1'b1;
      end else if (wr_status_s && bus.writedata[1]) begin
        dropped_r <= 1'b0;
      end
    end
  end

  // Conversion FSM; digit registers change only in LOAD or on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      busy_r    <= 1'b0;
      hexmode_r <= 1'b0;
      blank_r   <= 1'b0;
      neg_r     <= 1'b0;
      bcd_r     <= 20'd0;
      mag_r     <= 16'd0;
      cnt_r     <= 5'd0;
      digit0_r  <= SEG_ZERO;
      digit1_r  <= SEG_BLANK;
      digit2_r  <= SEG_BLANK;
      digit3_r  <= SEG_BLANK;
      digit4_r  <= SEG_BLANK;
      digit5_r  <= SEG_BLANK;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= ABS;
            busy_r  <= 1'b1;
          end
        end
        ABS: begin
          // Hex mode keeps the raw value in mag so LOAD can read its nibbles.
          hexmode_r <= ctrl_r[1];
          blank_r   <= ctrl_r[2];
          neg_r     <= ~ctrl_r[1] & value_r[15];
          mag_r     <= (~ctrl_r[1] & value_r[15]) ? (16'd0 - value_r) : value_r;
          bcd_r     <= 20'd0;
          cnt_r     <= 5'd0;
          state_r   <= ctrl_r[1] ? LOAD : SHIFT;
        end
        SHIFT: begin
          {bcd_r, mag_r} <= shifted_s;
          cnt_r          <= cnt_r + 5'd1;
          if (cnt_r == 5'd15) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          digit0_r <= next0_s;
          digit1_r <= next1_s;
          digit2_r <= next2_s;
          digit3_r <= next3_s;
          digit4_r <= next4_s;
          digit5_r <= next5_s;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-wait-state read mux straight from the registers.
  always_comb begin
    case (bus.address)
      2'd0:    bus.readdata = {16'd0, value_r};
      2'd1:    bus.readdata = {29'd0, ctrl_r};
      2'd2:    bus.readdata = {30'd0, dropped_r, busy_r};
      default: bus.readdata = 32'd0;
    endcase
  end

  // The enable gate uses the live CTRL bit so blanking the display is immediate.
  assign hex0 = ctrl_r[0] ? digit0_r : SEG_BLANK;
  assign hex1 = ctrl_r[0] ? digit1_r : SEG_BLANK;
  assign hex2 = ctrl_r[0] ? digit2_r : SEG_BLANK;
  assign hex3 = ctrl_r[0] ? digit3_r : SEG_BLANK;
  assign hex4 = ctrl_r[0] ? digit4_r : SEG_BLANK;
  assign hex5 = ctrl_r[0] ? digit5_r : SEG_BLANK;

endmodule
